// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem_pipe data-memory port: lane geometry
// helpers, the byte-enable merge and the clear-sweep FSM encoding.
package dmem_pkg;

  // Widest data word the merge helper handles; callers cast in and out.
  localparam int MAX_DATA_W = 1024;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } clr_state_e;

  // Number of byte lanes in a data word (BE_W).
  function automatic int calc_be_w(input int data_w);
    return data_w / 8;
  endfunction

  // Number of byte-offset bits in an address (OFF_W).
  function automatic int calc_off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Replace the lanes of old_word whose enable bit is set with new_word's lanes.
  function automatic logic [MAX_DATA_W-1:0] be_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage: one synchronous port with byte-enable write.
// A write and read of the same word on the same edge returns the merged
// (new) word, so the port behaves write-first.
module dmem_array import dmem_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                                     clk,
  input  logic                                     we,
  input  logic [DATA_W/8-1:0]                      be,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] addr,
  input  logic [DATA_W-1:0]                        wdata,
  output logic [DATA_W-1:0]                        rdata
);

  localparam int BE_W = calc_be_w(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] merged;

  // Word as it will look after this edge's write, used for the read bypass.
  always_comb begin
    merged = DATA_W'(be_merge(MAX_DATA_W'(mem[addr]), MAX_DATA_W'(wdata), MAX_BE_W'(be)));
  end

  // Lane-wise write commit and registered read.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= we ? merged : mem[addr];
  end

endmodule

// File: rtl/dmem_pipe.sv
// Pipelined data-memory port for the MEM stage. Requests are registered in
// S1, access the array on the following edge, then travel READ_LAT-1 further
// response registers, so every accepted request answers exactly READ_LAT
// cycles later, in order. Misaligned or out-of-range addresses answer with
// rsp_err=1, rsp_rdata=0 and never write the array.
//
// Optional build macro DMEM_CLEAR_EN: after reset a sweep zeroes every word
// before requests are accepted.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_CLEAR | sweeping: word[clr_cnt] <= 0 each cycle, req_ready = 0
//   ST_RUN   | normal operation, req_ready = 1
module dmem_pipe import dmem_pkg::*; #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int BE_W  = calc_be_w(DATA_W);
  localparam int OFF_W = calc_off_w(DATA_W);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NPIPE = READ_LAT - 1;

  logic              accept;
  logic [ADDR_W-1:0] widx;
  logic              misaligned;
  logic              range_err;

  logic              s1_valid;
  logic              s1_write;
  logic              s1_err;
  logic [AW-1:0]     s1_idx;
  logic [DATA_W-1:0] s1_wdata;
  logic [BE_W-1:0]   s1_be;

  logic              arr_we;
  logic [AW-1:0]     arr_addr;
  logic [BE_W-1:0]   arr_be;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  logic              s2_valid;
  logic              s2_write;
  logic              s2_err;
  logic [DATA_W-1:0] s2_data;

  logic              p_valid [NPIPE];
  logic              p_write [NPIPE];
  logic              p_err   [NPIPE];
  logic [DATA_W-1:0] p_data  [NPIPE];

  assign accept = req_valid && req_ready;

  // Address decode on the incoming request.
  always_comb begin
    widx       = req_addr >> OFF_W;
    misaligned = (req_addr & ADDR_W'(BE_W - 1)) != '0;
    range_err  = widx >= ADDR_W'(DEPTH);
  end

`ifdef DMEM_CLEAR_EN
  clr_state_e    state;
  clr_state_e    state_nx;
  logic [AW-1:0] clr_cnt;
  logic [AW-1:0] clr_cnt_nx;
  logic          clr_we;

  // Clear FSM state and sweep counter; reset restarts the sweep at word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nx;
      clr_cnt <= clr_cnt_nx;
    end
  end

  // Clear FSM next state, sweep write strobe and request readiness.
  always_comb begin
    state_nx   = state;
    clr_cnt_nx = clr_cnt;
    clr_we     = 1'b0;
    req_ready  = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we     = 1'b1;
        clr_cnt_nx = clr_cnt + AW'(1);
        if (clr_cnt == AW'(DEPTH - 1)) begin
          state_nx   = ST_RUN;
          clr_cnt_nx = '0;
        end
      end
      ST_RUN: begin
        req_ready = 1'b1;
      end
    endcase
  end
`else
  assign req_ready = 1'b1;
`endif

  // S1 request register; payload only loads on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
    end
    if (accept) begin
      s1_write <= req_write;
      s1_err   <= misaligned || range_err;
      s1_idx   <= widx[AW-1:0];
      s1_wdata <= req_wdata;
      s1_be    <= req_be;
    end
  end

  // Array port steering: S1 access, or the clear sweep when it is running.
  // Reset blocks any write so a store caught in S1 is dropped.
  always_comb begin
    arr_we    = !rst && s1_valid && s1_write && !s1_err;
    arr_addr  = s1_idx;
    arr_be    = s1_be;
    arr_wdata = s1_wdata;
`ifdef DMEM_CLEAR_EN
    if (clr_we) begin
      arr_we    = !rst;
      arr_addr  = clr_cnt;
      arr_be    = '1;
      arr_wdata = '0;
    end
`endif
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (arr_be),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // Control that lines up with the array's registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_write <= 1'b0;
      s2_err   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_write <= s1_write;
      s2_err   <= s1_err;
    end
  end

  // Writes and errors return zero data.
  assign s2_data = (s2_valid && !s2_write && !s2_err) ? arr_rdata : '0;

  // Response delay line; its last stage drives the response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NPIPE; i++) begin
        p_valid[i] <= 1'b0;
        p_write[i] <= 1'b0;
        p_err[i]   <= 1'b0;
        p_data[i]  <= '0;
      end
    end else begin
      p_valid[0] <= s2_valid;
      p_write[0] <= s2_valid && s2_write;
      p_err[0]   <= s2_valid && s2_err;
      p_data[0]  <= s2_data;
      for (int i = 1; i < NPIPE; i++) begin
        p_valid[i] <= p_valid[i-1];
        p_write[i] <= p_write[i-1];
        p_err[i]   <= p_err[i-1];
        p_data[i]  <= p_data[i-1];
      end
    end
  end

  assign rsp_valid = p_valid[NPIPE-1];
  assign rsp_write = p_write[NPIPE-1];
  assign rsp_err   = p_err[NPIPE-1];
  assign rsp_rdata = p_data[NPIPE-1];

endmodule
